// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared constants and FSM encoding for the SPI ADC responder
package sim_pkg;

   localparam int ADC_BITS = 12;
   localparam int CMD_BITS = 3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_CMD   = 3'd2;
   localparam logic [2:0] ST_NULLB = 3'd3;
   localparam logic [2:0] ST_DATA  = 3'd4;
   localparam logic [2:0] ST_TAIL  = 3'd5;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - multi-flop synchroniser with rise/fall pulse detection
module edge_sync #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic global_safe_rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;
   logic              sync_q;

   // Chain resets low so a chip select already held low never reads as a fresh falling edge.
   always_ff @(posedge CLK or posedge global_safe_rst) begin
      if (global_safe_rst) begin
         sync_r <= '0;
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], din};
         prev_r <= sync_r[STAGES-1];
      end
   end

   assign sync_q = sync_r[STAGES-1];
   assign rise   = sync_q & ~prev_r;
   assign fall   = ~sync_q & prev_r;

endmodule

// File: rtl/spi_adc_responder.sv
// rtl/spi_adc_responder.sv - oversampled SPI responder emulating a 2-channel 12-bit serial ADC
module spi_adc_responder
   import sim_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                CLK,
   input  logic                global_safe_rst,
   input  logic                spi_sck,
   input  logic                spi_cs_n,
   input  logic                spi_mosi,
   output logic                spi_miso,
   input  logic [ADC_BITS-1:0] ch0_value,
   input  logic [ADC_BITS-1:0] ch1_value,
   output logic                conv_done,
   output logic                last_ch,
   output logic                frame_err
);

   localparam logic [3:0] CNT_CMD  = 4'(CMD_BITS);
   localparam logic [3:0] CNT_DATA = 4'(ADC_BITS);
   localparam logic [3:0] CNT_TAIL = 4'(ADC_BITS - 1);

   logic                sck_rise;
   logic                sck_fall;
   logic                cs_rise;
   logic                cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                mosi_s;

   logic [2:0]          state;
   logic [3:0]          bit_cnt;
   logic [ADC_BITS-1:0] shreg;
   logic                sgl_r;
   logic                msbf_r;
   logic                b0_seen;

   logic [ADC_BITS:0]   diff01;
   logic [ADC_BITS:0]   diff10;
   logic [ADC_BITS-1:0] snap_val;

   edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .CLK             (CLK),
      .global_safe_rst (global_safe_rst),
      .din             (spi_sck),
      .rise            (sck_rise),
      .fall            (sck_fall)
   );

   // CS is active low: the pin falling edge is the frame start.
   edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .CLK             (CLK),
      .global_safe_rst (global_safe_rst),
      .din             (spi_cs_n),
      .rise            (cs_rise),
      .fall            (cs_fall)
   );

   // MOSI needs the same delay as SCK so the sampled bit lines up with the rise pulse.
   always_ff @(posedge CLK or posedge global_safe_rst) begin
      if (global_safe_rst) begin
         mosi_sync <= '0;
      end else begin
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign diff01 = {1'b0, ch0_value} - {1'b0, ch1_value};
   assign diff10 = {1'b0, ch1_value} - {1'b0, ch0_value};

   // Value to capture on the ODD rising edge; the live MOSI bit is the ODD bit itself.
   always_comb begin
      snap_val = '0;
      if (sgl_r) begin
         snap_val = mosi_s ? ch1_value : ch0_value;
      end else if (!mosi_s) begin
         snap_val = diff01[ADC_BITS] ? '0 : diff01[ADC_BITS-1:0];
      end else begin
         snap_val = diff10[ADC_BITS] ? '0 : diff10[ADC_BITS-1:0];
      end
   end

   // Frame FSM: CS rise has priority over any SCK edge seen in the same cycle.
   always_ff @(posedge CLK or posedge global_safe_rst) begin
      if (global_safe_rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         sgl_r     <= 1'b0;
         msbf_r    <= 1'b0;
         b0_seen   <= 1'b0;
         spi_miso  <= 1'b0;
         conv_done <= 1'b0;
         frame_err <= 1'b0;
         last_ch   <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         frame_err <= 1'b0;
         if (cs_rise) begin
            state     <= ST_IDLE;
            spi_miso  <= 1'b0;
            frame_err <= (state == ST_CMD) || (state == ST_NULLB) ||
                         ((state == ST_DATA) && !b0_seen);
         end else begin
            case (state)
               ST_IDLE: begin
                  spi_miso <= 1'b0;
                  if (cs_fall) begin
                     state   <= ST_START;
                     bit_cnt <= '0;
                     b0_seen <= 1'b0;
                  end
               end
               ST_START: begin
                  if (sck_rise && mosi_s) begin
                     state   <= ST_CMD;
                     bit_cnt <= '0;
                  end
               end
               ST_CMD: begin
                  if (sck_rise && (bit_cnt < CNT_CMD)) begin
                     case (bit_cnt)
                        4'd0: sgl_r <= mosi_s;
                        4'd1: begin
                           shreg   <= snap_val;
                           last_ch <= mosi_s;
                        end
                        default: msbf_r <= mosi_s;
                     endcase
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (sck_fall && (bit_cnt == CNT_CMD)) begin
                     spi_miso <= 1'b0;
                     state    <= ST_NULLB;
                  end
               end
               ST_NULLB: begin
                  if (sck_fall) begin
                     spi_miso <= shreg[ADC_BITS-1];
                     shreg    <= {shreg[ADC_BITS-2:0], shreg[ADC_BITS-1]};
                     bit_cnt  <= 4'd1;
                     state    <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (sck_rise && (bit_cnt == CNT_DATA) && !b0_seen) begin
                     conv_done <= 1'b1;
                     b0_seen   <= 1'b1;
                  end else if (sck_fall) begin
                     if (bit_cnt == CNT_DATA) begin
                        // Twelve left rotations restored the word, so B1 sits at bit 1.
                        spi_miso <= msbf_r ? 1'b0 : shreg[1];
                        shreg    <= {shreg[0], shreg[ADC_BITS-1:1]};
                        bit_cnt  <= 4'd1;
                        state    <= ST_TAIL;
                     end else begin
                        spi_miso <= shreg[ADC_BITS-1];
                        shreg    <= {shreg[ADC_BITS-2:0], shreg[ADC_BITS-1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                     end
                  end
               end
               ST_TAIL: begin
                  if (sck_fall) begin
                     if (!msbf_r && (bit_cnt < CNT_TAIL)) begin
                        spi_miso <= shreg[1];
                        shreg    <= {shreg[0], shreg[ADC_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                     end else begin
                        spi_miso <= 1'b0;
                     end
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  spi_miso <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_adc_responder.sv
// tb/tb_spi_adc_responder.sv - directed self-checking bench for spi_adc_responder
module tb_spi_adc_responder;

   localparam int HALF = 6;

   logic        CLK = 1'b0;
   logic        global_safe_rst;
   logic        spi_sck;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso;
   logic [11:0] ch0_value;
   logic [11:0] ch1_value;
   logic        conv_done;
   logic        last_ch;
   logic        frame_err;

   int n_cmp = 0;
   int n_bad = 0;
   int conv_cnt = 0;
   int err_cnt = 0;
   int conv_base = 0;
   int err_base = 0;
   logic rx [0:63];

   always #5 CLK = ~CLK;

   spi_adc_responder #(.SYNC_STAGES(2)) dut (
      .CLK             (CLK),
      .global_safe_rst (global_safe_rst),
      .spi_sck         (spi_sck),
      .spi_cs_n        (spi_cs_n),
      .spi_mosi        (spi_mosi),
      .spi_miso        (spi_miso),
      .ch0_value       (ch0_value),
      .ch1_value       (ch1_value),
      .conv_done       (conv_done),
      .last_ch         (last_ch),
      .frame_err       (frame_err)
   );

   always @(negedge CLK) begin
      if (conv_done) conv_cnt++;
      if (frame_err) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic sck_bit(input logic b, output logic m);
      spi_mosi = b;
      wait_clk(HALF);
      m = spi_miso;
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
   endtask

   task automatic run_frame(input int lead, input logic [3:0] cmd, input int nsck,
                            input int chg_idx, input logic [11:0] chg_val);
      logic m;
      conv_base = conv_cnt;
      err_base  = err_cnt;
      spi_cs_n  = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < lead; i++) sck_bit(1'b0, m);
      for (int i = 0; i < nsck; i++) begin
         if (i == chg_idx) ch0_value = chg_val;
         sck_bit((i < 4) ? cmd[3-i] : 1'b0, m);
         rx[i] = m;
      end
   endtask

   task automatic end_frame();
      wait_clk(HALF);
      spi_cs_n = 1'b1;
      wait_clk(2 * HALF);
   endtask

   function automatic logic [11:0] word_at(input int s);
      logic [11:0] w;
      for (int k = 0; k < 12; k++) w[11-k] = rx[s+k];
      return w;
   endfunction

   function automatic logic [10:0] tail_at(input int s);
      logic [10:0] t;
      for (int k = 0; k < 11; k++) t[10-k] = rx[s+k];
      return t;
   endfunction

   initial begin
      global_safe_rst = 1'b1;
      spi_sck   = 1'b0;
      spi_cs_n  = 1'b1;
      spi_mosi  = 1'b0;
      ch0_value = 12'h000;
      ch1_value = 12'h000;
      wait_clk(4);
      chk("rst_miso", spi_miso, 0);
      chk("rst_conv", conv_done, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_lastch", last_ch, 0);
      global_safe_rst = 1'b0;
      wait_clk(6);

      // single-ended ch0, MSB-first, extra clocks read zeros
      ch0_value = 12'hA5C;
      run_frame(0, 4'b1101, 20, -1, 12'h000);
      chk("t1_null", rx[4], 0);
      chk("t1_word", word_at(5), 12'hA5C);
      chk("t1_tail0", {rx[17], rx[18], rx[19]}, 3'b000);
      chk("t1_conv", conv_cnt - conv_base, 1);
      chk("t1_lastch", last_ch, 0);
      end_frame();
      chk("t1_ferr", err_cnt - err_base, 0);

      // single-ended ch1, LSB-first continuation
      ch1_value = 12'h001;
      run_frame(0, 4'b1110, 29, -1, 12'h000);
      chk("t2_word", word_at(5), 12'h001);
      chk("t2_tail", tail_at(17), 11'h000);
      chk("t2_end", rx[28], 0);
      chk("t2_lastch", last_ch, 1);
      end_frame();

      ch1_value = 12'hA5C;
      run_frame(0, 4'b1110, 29, -1, 12'h000);
      chk("t2b_word", word_at(5), 12'hA5C);
      chk("t2b_tail", tail_at(17), 11'h3A5);
      chk("t2b_end", rx[28], 0);
      end_frame();

      // differential with clamp
      ch0_value = 12'h100;
      ch1_value = 12'h300;
      run_frame(0, 4'b1001, 17, -1, 12'h000);
      chk("t3_clamp", word_at(5), 12'h000);
      chk("t3_lastch0", last_ch, 0);
      end_frame();
      run_frame(0, 4'b1011, 17, -1, 12'h000);
      chk("t3_diff10", word_at(5), 12'h200);
      chk("t3_lastch1", last_ch, 1);
      end_frame();
      ch0_value = 12'h300;
      ch1_value = 12'h100;
      run_frame(0, 4'b1001, 17, -1, 12'h000);
      chk("t3_diff01", word_at(5), 12'h200);
      end_frame();

      // leading zeros, snapshot held while ch0 changes mid-data
      ch0_value = 12'h7FF;
      run_frame(5, 4'b1101, 17, 8, 12'h000);
      chk("t4_word", word_at(5), 12'h7FF);
      chk("t4_conv", conv_cnt - conv_base, 1);
      end_frame();

      // abort after 6 data bits
      ch0_value = 12'hFFF;
      run_frame(0, 4'b1101, 11, -1, 12'h000);
      wait_clk(4);
      chk("t5_miso_hi", spi_miso, 1);
      spi_cs_n = 1'b1;
      wait_clk(3);
      chk("t5_miso_lo", spi_miso, 0);
      wait_clk(10);
      chk("t5_ferr", err_cnt - err_base, 1);
      chk("t5_conv", conv_cnt - conv_base, 0);
      ch0_value = 12'h3C5;
      run_frame(0, 4'b1101, 17, -1, 12'h000);
      chk("t5_next", word_at(5), 12'h3C5);
      chk("t5_next_ferr", err_cnt - err_base, 0);
      end_frame();

      // reset in the middle of DATA
      ch1_value = 12'hFFF;
      run_frame(0, 4'b1111, 8, -1, 12'h000);
      wait_clk(4);
      chk("t6_miso_hi", spi_miso, 1);
      chk("t6_lastch_hi", last_ch, 1);
      global_safe_rst = 1'b1;
      #1;
      chk("t6_rst_miso", spi_miso, 0);
      chk("t6_rst_conv", conv_done, 0);
      chk("t6_rst_ferr", frame_err, 0);
      chk("t6_rst_lastch", last_ch, 0);
      wait_clk(3);
      global_safe_rst = 1'b0;
      wait_clk(2);
      spi_cs_n = 1'b1;
      wait_clk(2 * HALF);
      chk("t6_no_ferr", err_cnt - err_base, 0);
      ch1_value = 12'h5A3;
      run_frame(0, 4'b1111, 17, -1, 12'h000);
      chk("t6_word", word_at(5), 12'h5A3);
      chk("t6_conv", conv_cnt - conv_base, 1);
      chk("t6_lastch", last_ch, 1);
      end_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

SPI responder that emulates the board's 2-channel 12-bit serial ADC (MCP3202-style framing) at the far end of the SPI_SCK / SPI_AD / SPI_DIN / SPI_DOUT link. It serves the accelerator and CdS readings without the physical chip, for bench loopback and hardware-in-the-loop runs. The block receives the initiator's command bits, snapshots the selected channel value, and shifts it back MSB-first. Everything runs in the CLK domain; SPI pins are oversampled, never used as clocks.

## Interface
- SYNC_STAGES, 2, synchroniser depth on spi_sck, spi_cs_n and spi_mosi (minimum 2).
- CLK  in  1  system clock.
- global_safe_rst  in  1  reset; asynchronous, active-high; clock CLK.
- spi_sck  in  1  SPI clock from the initiator; idle low (mode 0,0).
- spi_cs_n  in  1  chip select, active low (SPI_AD).
- spi_mosi  in  1  command bits from the initiator (SPI_DIN).
- spi_miso  out  1  response bits to the initiator (SPI_DOUT); reset 0.
- ch0_value  in  12  value served on channel 0 (accelerator).
- ch1_value  in  12  value served on channel 1 (CdS).
- conv_done  out  1  one-CLK pulse when the initiator samples data bit B0; reset 0.
- last_ch  out  1  channel (ODD bit) of the last accepted command; reset 0.
- frame_err  out  1  one-CLK pulse when CS deasserts before B0 is sampled; reset 0.

## Operation
- Input conditioning: spi_sck, spi_cs_n, spi_mosi pass through SYNC_STAGES flops; rise/fall detectors on the synchronised SCK; the CS falling edge is detected on the synchronised CS.
- MOSI is sampled on SCK rising edges; spi_miso changes only on SCK falling edges (or on CS events, as below).
- FSM states: IDLE, START, CMD, NULLB, DATA, TAIL.
- IDLE: spi_miso = 0. CS falling edge -> START.
- START: leading 0 bits are ignored. The first rising edge with MOSI = 1 -> CMD, with the bit counter cleared.
- CMD: three rising edges capture SGL, ODD, MSBF in that order. On the ODD rising edge the selected value is snapshotted into a 12-bit shift register and last_ch <= ODD.
- Snapshot value:
  - SGL = 1: value = ODD ? ch1_value : ch0_value.
  - SGL = 0, ODD = 0: value = ch0 - ch1, clamped to 0 if negative.
  - SGL = 0, ODD = 1: value = ch1 - ch0, clamped to 0 if negative.
  - Subtraction is done 13-bit; the result is 12-bit unsigned.
- NULLB: on the falling edge after MSBF is captured, drive the null bit 0. Next falling edge -> DATA.
- DATA: successive falling edges drive B11..B0. The rising edge that samples B0 pulses conv_done. On the next falling edge -> TAIL.
- TAIL:
  - MSBF = 0: drive B1..B11 (LSB-first continuation, B0 not repeated), then 0.
  - MSBF = 1: drive 0 on every further falling edge.
- CS rising (synchronised), from any state: return to IDLE, spi_miso <= 0. Pulse frame_err if the state was CMD, NULLB, or DATA before conv_done fired. No error pulse from START.
- Reset mid-frame: all state cleared to IDLE. The next CS falling edge starts a fresh frame; an SCK activity in progress is ignored until then.
- ch0_value / ch1_value changing after the snapshot does not affect the frame in flight.

## Timing
- Requirement: SCK high time and low time ≥ (SYNC_STAGES + 2) CLK each; CS setup to first SCK rise ≥ (SYNC_STAGES + 2) CLK.
- MISO latency: spi_miso is updated SYNC_STAGES + 1 CLK after the pin-level SCK falling edge.
- conv_done asserts SYNC_STAGES + 1 CLK after the pin-level SCK rise that samples B0, for exactly 1 CLK.
- Simultaneous events: a CS rise and an SCK edge in the same synchronised cycle -> the CS rise wins and the SCK edge is discarded. A CS fall in the same cycle as an SCK rise -> the SCK rise is ignored.
- Frame length: 1 start + 3 cmd + 1 null + 12 data = 17 SCK cycles minimum after leading zeros.

## Structure
- Shared package (sim_pkg): FSM state encoding (IDLE..TAIL), ADC_BITS = 12, CMD_BITS = 3.
- One sub-module, edge_sync (parameterised synchroniser plus rise/fall detector), is instantiated for SCK and CS; MOSI uses the synchroniser only.
- Remaining logic in one module: FSM, 4-bit bit counter, 12-bit shift register, clamp subtractor.

## Test plan
- Single-ended ch0: ch0 = 0xA5C, command 1,1,0,1 (start, SGL, ODD = 0, MSBF) -> MISO null 0 then 1010_0101_1100; conv_done pulses once; last_ch = 0.
- Single-ended ch1, LSB-first tail: ch1 = 0x001, command 1,1,1,0, 29 SCKs -> B11..B0 = 0x001, then B1..B11 = 0 x11; last_ch = 1.
- Differential clamp: ch0 = 0x100, ch1 = 0x300. SGL = 0, ODD = 0 -> 0x000; SGL = 0, ODD = 1 -> 0x200.
- Leading zeros + snapshot hold: 5 zero bits before start; ch0 changed from 0x7FF to 0x000 during DATA -> 0x7FF returned.
- Abort: CS raised after 6 data bits -> frame_err 1 pulse, no conv_done, spi_miso = 0 within SYNC_STAGES + 1 CLK; next frame returns the correct value.
- Reset mid-DATA: global_safe_rst asserted -> spi_miso, conv_done, frame_err, last_ch all 0 immediately; the following complete frame is correct.
